hazard_scoreboard: RTL and testbench

- Parametrised scoreboard hazard unit for the ID stage of the pipelined MIPS core.
- Replaces fixed dest-vs-source comparison against two pipeline stages with a per-register pending-latency counter.
- Supports variable-latency producers (ALU, load, multi-cycle MUL), optional forwarding mode, WAW ordering protection, pipeline flush and a stall statistics counter.
- Output drives the IF/ID freeze and ID/EX bubble insertion.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-latency scoreboard for ID-stage hazard detection
// Each register carries a countdown of cycles until its pending value can be consumed.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_LAT     = 3,
    parameter int FWD_EN      = 1,
    parameter int WB_LAT      = 2,
    parameter int ZERO_REG_HW = 1,
    parameter int STAT_W      = 16,
    localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src1_used,
    input  logic                  src2_used,
    input  logic                  issue_wb_en,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [LAT_W-1:0]      issue_lat,
    input  logic                  flush,
    input  logic                  stat_clr,
    output logic                  hazard_detected,
    output logic                  issue_fire,
    output logic                  busy,
    output logic [STAT_W-1:0]     stall_count
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [LAT_W-1:0]  cnt_q [NUM_REGS];
    logic [LAT_W-1:0]  cnt_d [NUM_REGS];
    logic [STAT_W-1:0] stall_count_q;
    logic [STAT_W-1:0] stall_count_d;
    logic [LAT_W-1:0]  lat_eff;
    logic              raw;
    logic              waw;

    function automatic logic track(input logic [REG_ADDR_W-1:0] r);
        return !((ZERO_REG_HW != 0) && (r == '0));
    endfunction

    // Without forwarding every producer is only visible after write-back.
    always_comb begin
        lat_eff = LAT_W'(WB_LAT);
        if (FWD_EN != 0) begin
            lat_eff = (32'(issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;
        end
    end

    always_comb begin
        raw = (src1_used && track(src1) && (cnt_q[src1] != '0)) ||
              (src2_used && track(src2) && (cnt_q[src2] != '0));
        // An older write still landing later than this one would clobber it.
        waw = issue_wb_en && track(issue_dest) && (cnt_q[issue_dest] > lat_eff);
        hazard_detected = id_valid && (raw || waw);
        issue_fire      = id_valid && !hazard_detected;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy = busy | (cnt_q[i] != '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
        end
        if (issue_fire && issue_wb_en && track(issue_dest) && (lat_eff != '0)) begin
            cnt_d[issue_dest] = lat_eff;
        end
        if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = '0;
        end else if (hazard_detected && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
// Three configurations share stimulus: forwarding, no forwarding, 2-bit stall counter.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] src1 = '0, src2 = '0, dest = '0;
    logic       u1 = 1'b0, u2 = 1'b0, wb = 1'b0, fl = 1'b0, sclr = 1'b0;
    logic [1:0] lat_i = '0;
    logic [2:0] hz, fire, bz;
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int avail [3][32];
    int scnt [3];
    int st;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FWD_EN(1), .STAT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src1_used(u1), .src2_used(u2), .issue_wb_en(wb), .issue_dest(dest),
        .issue_lat(lat_i), .flush(fl), .stat_clr(sclr), .hazard_detected(hz[0]),
        .issue_fire(fire[0]), .busy(bz[0]), .stall_count(sc0));
    hazard_scoreboard #(.FWD_EN(0), .WB_LAT(2), .STAT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src1_used(u1), .src2_used(u2), .issue_wb_en(wb), .issue_dest(dest),
        .issue_lat(lat_i), .flush(fl), .stat_clr(sclr), .hazard_detected(hz[1]),
        .issue_fire(fire[1]), .busy(bz[1]), .stall_count(sc1));
    hazard_scoreboard #(.FWD_EN(1), .STAT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src1_used(u1), .src2_used(u2), .issue_wb_en(wb), .issue_dest(dest),
        .issue_lat(lat_i), .flush(fl), .stat_clr(sclr), .hazard_detected(hz[2]),
        .issue_fire(fire[2]), .busy(bz[2]), .stall_count(sc2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int act_sc(input int k);
        case (k)
            0:       return int'(sc0);
            1:       return int'(sc1);
            default: return int'(sc2);
        endcase
    endfunction

    // Model: each register remembers the absolute cycle at which it becomes readable.
    function automatic int rem(input int k, input int r);
        return (avail[k][r] > cyc) ? avail[k][r] - cyc : 0;
    endfunction

    function automatic int leff(input int k);
        if (k == 1) return 2;
        return (int'(lat_i) > 3) ? 3 : int'(lat_i);
    endfunction

    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                scnt[k] = 0;
                for (int r = 0; r < 32; r++) avail[k][r] = 0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            bit raw, waw, eh, ef, eb;
            int smax;
            smax = (k == 2) ? 3 : 65535;
            raw = (u1 && src1 != 0 && rem(k, int'(src1)) > 0) ||
                  (u2 && src2 != 0 && rem(k, int'(src2)) > 0);
            waw = wb && dest != 0 && rem(k, int'(dest)) > leff(k);
            eh = id_valid && (raw || waw);
            ef = id_valid && !eh;
            eb = 0;
            for (int r = 0; r < 32; r++) if (rem(k, r) > 0) eb = 1;
            chk($sformatf("hazard[%0d]", k), int'(hz[k]), int'(eh));
            chk($sformatf("issue_fire[%0d]", k), int'(fire[k]), int'(ef));
            chk($sformatf("busy[%0d]", k), int'(bz[k]), int'(eb));
            chk($sformatf("stall_count[%0d]", k), act_sc(k), scnt[k]);
            if (!rst) begin
                if (sclr) scnt[k] = 0;
                else if (eh && scnt[k] < smax) scnt[k]++;
                if (fl) begin
                    for (int r = 0; r < 32; r++) avail[k][r] = 0;
                end else if (ef && wb && dest != 0 && leff(k) > 0) begin
                    avail[k][dest] = cyc + 1 + leff(k);
                end
            end
        end
        cyc++;
    end

    task automatic set_in(input bit v, input int s1, input bit a1, input int s2, input bit a2,
                          input bit w, input int d, input int l, input bit f);
        id_valid = v; src1 = 5'(s1); u1 = a1; src2 = 5'(s2); u2 = a2;
        wb = w; dest = 5'(d); lat_i = 2'(l); fl = f;
    endtask

    task automatic drive(input bit v, input int s1, input bit a1, input int s2, input bit a2,
                         input bit w, input int d, input int l, input bit f);
        @(negedge clk);
        set_in(v, s1, a1, s2, a2, w, d, l, f);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sclr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds one instruction in ID until instance k lets it issue; returns stall cycles seen.
    task automatic until_fire(input int k, input int s1, input bit a1, input int s2, input bit a2,
                              input bit w, input int d, input int l, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, s1, a1, s2, a2, w, d, l, 0);
            #1;
            if (!hz[k]) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) chk("issue_timeout", 0, 1);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_hazard", int'(hz[0]), 0);
        chk("reset_busy", int'(bz[0]), 0);
        chk("reset_stall", int'(sc0), 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a stall
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 3, 0);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_hazard", int'(hz[0]), 1);
        chk("pre_rst_stall", int'(sc0), 1);
        rst = 1'b1;
        #1;
        chk("rst_hazard", int'(hz[0]), 0);
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_stall", int'(sc0), 0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // No forwarding: ALU write r5 then a reader waits the full write-back distance
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        until_fire(1, 5, 1, 0, 0, 0, 0, 0, st);
        chk("nofwd_stalls", st, 2);
        idle();
        #1;
        chk("nofwd_stall_count", int'(sc1), 2);
        chk("fwd_alu_stall_count", int'(sc0), 0);

        // Forwarding: load-use costs one cycle, ALU-use costs none
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0);
        until_fire(0, 4, 1, 0, 0, 1, 8, 0, st);
        chk("load_use_stalls", st, 1);
        drive(1, 0, 0, 0, 0, 1, 4, 0, 0);
        until_fire(0, 4, 1, 0, 0, 0, 0, 0, st);
        chk("alu_use_stalls", st, 0);

        // Register 0 is never tracked
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
        idle();
        #1;
        chk("r0_busy", int'(bz[0]), 0);
        until_fire(0, 0, 1, 0, 0, 0, 0, 0, st);
        chk("r0_stalls", st, 0);

        // Unused source is masked
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 3, 0);
        until_fire(0, 1, 1, 3, 0, 1, 6, 0, st);
        chk("masked_src2_stalls", st, 0);

        // WAW ordering
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 3, 0);
        until_fire(0, 0, 0, 0, 0, 1, 3, 0, st);
        chk("waw_alu_stalls", st, 3);
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 3, 0);
        until_fire(0, 0, 0, 0, 0, 1, 3, 1, st);
        chk("waw_load_stalls", st, 2);

        // Flush discards tracking and the same-cycle issue
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 9, 3, 0);
        drive(1, 0, 0, 0, 0, 1, 10, 1, 1);
        idle();
        #1;
        chk("flush_busy", int'(bz[0]), 0);
        until_fire(0, 9, 1, 10, 1, 0, 0, 0, st);
        chk("flush_read_stalls", st, 0);

        // Stall counter saturation and clear
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 3, 0);
        for (int i = 0; i < 8; i++) drive(1, 3, 1, 0, 0, 1, 3, 3, 0);
        idle();
        #1;
        chk("sat_stall_count", int'(sc2), 3);
        chk("wide_stall_count", int'(sc0), 6);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        sclr = 1'b1;
        #1;
        chk("clr_cycle_hazard", int'(hz[0]), 1);
        @(negedge clk);
        sclr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("clr_sat_count", int'(sc2), 0);
        chk("clr_wide_count", int'(sc0), 0);

        repeat (4) idle();
        @(negedge clk);
        #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
